glitch_filter_bank: RTL and testbench
=====================================

Name: glitch_filter_bank

Overview:
- Multi-channel successor to the single-bit glitch filter.
- Each channel has:
  - a parametrised input synchroniser;
  - a stable-count filter that requires FILTER_CYCLE consecutive mismatching samples before the output changes;
  - registered rise/fall pulses and a sticky change flag with write-1-clear.
- Sits between raw pads (joystick, keys, IEC, user port) and core logic. Drives an aggregated change interrupt.

Parameters:
- CHANNELS, 8: number of independent filter channels (1..32).
- FILTER_CYCLE, 3: consecutive mismatching synchronised samples needed to accept a new level (1..65535).
- SYNC_STAGES, 2: input synchroniser depth, 0..4. 0 means din is used directly.
- RESET_VAL, 0: reset level of the synchronisers and dout, replicated on all channels.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- din  in  CHANNELS  raw asynchronous inputs.
- bypass  in  CHANNELS  per-channel filter bypass. Quasi-static.
- chg_clr  in  CHANNELS  one-cycle write-1-clear for chg_sticky.
- irq_mask  in  CHANNELS  1 = channel contributes to irq.
- dout  out  CHANNELS  filtered levels, registered.
- rise  out  CHANNELS  one-cycle pulse when dout goes 0->1.
- fall  out  CHANNELS  one-cycle pulse when dout goes 1->0.
- chg_sticky  out  CHANNELS  latched "dout changed" flags.
- irq  out  1  OR of (chg_sticky & irq_mask), combinational from registers.

Behaviour:
- Single clock domain. All flops reset asynchronously on rstn low.
- Reset values:
  - sync chain = RESET_VAL;
  - dout = RESET_VAL;
  - cnt = 0;
  - rise, fall, chg_sticky = 0;
  - irq = 0.
  - No edge pulse is generated on reset release if din equals RESET_VAL.
- Synchroniser: s[i] is the last stage of a SYNC_STAGES-deep shift register on din[i]. With SYNC_STAGES=0, s[i]=din[i].
- Counter: per channel, width $clog2(max(FILTER_CYCLE,2)).
- Filter mode (bypass[i]=0), each edge:
  - s==dout: cnt<=0 (mismatch run broken; glitch discarded).
  - s!=dout and cnt<FILTER_CYCLE-1: cnt<=cnt+1.
  - s!=dout and cnt==FILTER_CYCLE-1: dout<=s, cnt<=0.
  - FILTER_CYCLE=1: dout follows s with one register of delay.
- Latency: din stable from sampling edge 0 gives a dout change at edge SYNC_STAGES+FILTER_CYCLE-1. That is SYNC_STAGES+FILTER_CYCLE clocks.
- Pulse suppression: any s pulse shorter than FILTER_CYCLE clocks never reaches dout.
- Bypass mode (bypass[i]=1): dout<=s every edge, cnt held at 0.
  - Entering bypass mid-count discards the count.
  - Leaving bypass starts from cnt=0.
- Edge pulses:
  - rise<=(next dout & ~dout), fall<=(~next dout & dout).
  - Asserted in the same cycle dout shows the new level, for exactly one cycle.
  - Never both at once.
- Sticky flag:
  - chg_sticky[i] set on any dout change. Cleared when chg_clr[i]=1.
  - Set and clear in the same cycle: set wins (no lost event).
- Channels are fully independent. Simultaneous changes on several channels are all reported in the same cycle.
- Counter never wraps: saturation at FILTER_CYCLE-1 is impossible because the accept clears it.

Test Plan:
- Reset/idle: rstn low with din=0 (RESET_VAL=0), then release, hold 20 clk -> dout=0, rise=fall=0, chg_sticky=0, irq=0 throughout.
- Clean edge, defaults: din[0] 0->1 before edge 0 and held -> dout[0]=1 after edge 4. rise[0]=1 for exactly that cycle. chg_sticky[0]=1. irq=1 with irq_mask[0]=1, irq=0 with mask cleared.
- Glitch rejection: din[3] high for exactly 2 clk, then low -> dout[3], rise, fall stay 0.
- Glitch boundary: din[3] high for exactly 3 clk -> dout[3] high for exactly 3 clk. One rise pulse, then one fall pulse.
- Interrupted run: din[5] high 2 clk, low 1 clk, high 3 clk -> dout[5] rises only 4 clk after the start of the second high run (counter restart verified).
- Bypass and sticky race: bypass[2]=1, toggle din[2] every clk -> dout[2] follows with 2-clk lag and pulses every cycle. Assert chg_clr[2] during a change cycle -> chg_sticky[2] remains 1. Assert again with bypass[2]=0 and din static -> chg_sticky[2] clears. Async rstn pulse mid-run -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/glitch_filter_bank.sv
// ---------------------------------------------------------------------------
// glitch_filter_bank
//
// Purpose:
//   A bank of independent single-bit glitch filters. These filters sit between
//   raw pads (joystick, keys, IEC, user port) and the core logic.
//
//   Each channel has three parts:
//     - an optional input synchroniser;
//     - a stable-count filter;
//     - registered edge pulses and a sticky change flag.
//
//   A new level is accepted only after FILTER_CYCLE consecutive synchronised
//   samples that differ from the current output. Any agreeing sample in
//   between discards the run.
//
// Parameters:
//   CHANNELS      number of independent channels (1..32)
//   FILTER_CYCLE  consecutive mismatching samples needed to accept (1..65535)
//   SYNC_STAGES   synchroniser depth (0..4); 0 uses din directly
//   RESET_VAL     reset level of the synchronisers and dout (all channels)
//
// Ports:
//   clk         system clock
//   rstn        asynchronous active-low reset
//   din         raw asynchronous inputs
//   bypass      per-channel filter bypass (quasi-static)
//   chg_clr     one-cycle write-1-clear for chg_sticky
//   irq_mask    1 = channel contributes to irq
//   dout        filtered levels (registered)
//   rise        one-cycle pulse when dout goes 0->1
//   fall        one-cycle pulse when dout goes 1->0
//   chg_sticky  latched "dout changed" flags
//   irq         OR of (chg_sticky & irq_mask)
// ---------------------------------------------------------------------------
module glitch_filter_bank #(
    parameter int CHANNELS     = 8,
    parameter int FILTER_CYCLE = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int RESET_VAL    = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [CHANNELS-1:0] din,
    input  logic [CHANNELS-1:0] bypass,
    input  logic [CHANNELS-1:0] chg_clr,
    input  logic [CHANNELS-1:0] irq_mask,
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] chg_sticky,
    output logic                irq
);

    // The counter only has to reach FILTER_CYCLE-1. Keep at least one bit so
    // that FILTER_CYCLE=1 still elaborates; in that case it simply stays 0.
    localparam int                  CNT_W    = $clog2((FILTER_CYCLE > 2) ? FILTER_CYCLE : 2);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(FILTER_CYCLE - 1);
    localparam logic                RST_BIT  = (RESET_VAL != 0);
    localparam logic [CHANNELS-1:0] RST_VEC  = {CHANNELS{RST_BIT}};

    logic [CHANNELS-1:0] w_s;
    logic [CHANNELS-1:0] w_dout_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt [CHANNELS];

    logic [CHANNELS-1:0] r_dout;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic [CHANNELS-1:0] r_sticky;
    logic [CNT_W-1:0]    r_cnt [CHANNELS];

    // ------------------------------------------------------------------
    // Input synchroniser: s is the last stage of the shift register, or
    // din itself when no synchronisation is requested.
    // ------------------------------------------------------------------
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = din;
        end else begin : g_sync
            logic [CHANNELS-1:0] r_sync [SYNC_STAGES];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= RST_VEC;
                    end
                end else begin
                    r_sync[0] <= din;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stable-count filter, next-state logic.
    // The counter is cleared on every agreeing sample, on acceptance and
    // while bypassed. Because acceptance clears it, the counter never has
    // to wrap or saturate.
    // ------------------------------------------------------------------
    always_comb begin
        w_dout_nxt = r_dout;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_cnt_nxt[ch] = '0;
            if (bypass[ch]) begin
                w_dout_nxt[ch] = w_s[ch];
            end else if (w_s[ch] != r_dout[ch]) begin
                if (r_cnt[ch] == CNT_LAST) begin
                    w_dout_nxt[ch] = w_s[ch];
                end else begin
                    w_cnt_nxt[ch] = r_cnt[ch] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers.
    // The edge pulses are computed from the next level, so each pulse
    // appears in the same cycle as the new dout level. The sticky flag
    // lets a set beat a clear in the same cycle, so no event is lost.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dout   <= RST_VEC;
            r_rise   <= '0;
            r_fall   <= '0;
            r_sticky <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_cnt[ch] <= '0;
            end
        end else begin
            r_dout   <= w_dout_nxt;
            r_rise   <= w_dout_nxt & ~r_dout;
            r_fall   <= ~w_dout_nxt & r_dout;
            r_sticky <= (r_sticky & ~chg_clr) | (w_dout_nxt ^ r_dout);
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_cnt[ch] <= w_cnt_nxt[ch];
            end
        end
    end

    assign dout       = r_dout;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign chg_sticky = r_sticky;
    assign irq        = |(r_sticky & irq_mask);

endmodule

// File: tb/tb_glitch_filter_bank.sv
// ---------------------------------------------------------------------------
// tb_glitch_filter_bank
//
// Directed test of glitch_filter_bank with its default parameters
// (8 channels, FILTER_CYCLE=3, SYNC_STAGES=2, RESET_VAL=0).
//
// Each stimulus step pushes the outputs it implies onto a queue. Every entry
// is tagged with the clock edge after which it must hold. A negedge monitor
// pops the entries that are due and compares them against the DUT outputs.
//
// With this configuration, din driven just before edge E0 shows on dout
// after edge E0+4.
// ---------------------------------------------------------------------------
module tb_glitch_filter_bank;

    localparam int CH = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [CH-1:0] din = '0;
    logic [CH-1:0] bypass = '0;
    logic [CH-1:0] chg_clr = '0;
    logic [CH-1:0] irq_mask = 8'h01;
    logic [CH-1:0] dout;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] chg_sticky;
    logic          irq;

    glitch_filter_bank #(
        .CHANNELS     (CH),
        .FILTER_CYCLE (3),
        .SYNC_STAGES  (2),
        .RESET_VAL    (0)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .din        (din),
        .bypass     (bypass),
        .chg_clr    (chg_clr),
        .irq_mask   (irq_mask),
        .dout       (dout),
        .rise       (rise),
        .fall       (fall),
        .chg_sticky (chg_sticky),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge number N, cyc == N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Selectors: 0 dout, 1 rise, 2 fall, 3 chg_sticky, 4 irq (bit 0)
    typedef struct {
        int            cyc;
        int            sel;
        logic [CH-1:0] msk;
        logic [CH-1:0] val;
        string         tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void push(int c, int sel, logic [CH-1:0] m, logic [CH-1:0] v, string t);
        exp_t e;
        e.cyc = c;
        e.sel = sel;
        e.msk = m;
        e.val = v;
        e.tag = t;
        q.push_back(e);
    endfunction

    function automatic void push_zero(int c, string t);
        push(c, 0, 8'hFF, 8'h00, t);
        push(c, 1, 8'hFF, 8'h00, t);
        push(c, 2, 8'hFF, 8'h00, t);
        push(c, 3, 8'hFF, 8'h00, t);
        push(c, 4, 8'h01, 8'h00, t);
    endfunction

    function automatic logic [CH-1:0] pick(int sel);
        case (sel)
            0:       return dout;
            1:       return rise;
            2:       return fall;
            3:       return chg_sticky;
            default: return {{(CH-1){1'b0}}, irq};
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t          e;
        logic [CH-1:0] obs;
        for (int k = q.size() - 1; k >= 0; k--) begin
            if (q[k].cyc <= cyc) begin
                e   = q[k];
                obs = pick(e.sel);
                checks++;
                assert (e.cyc == cyc && (obs & e.msk) === (e.val & e.msk))
                else begin
                    errors++;
                    $error("FAIL %s (sel %0d, edge %0d/%0d): observed %h expected %h",
                           e.tag, e.sel, cyc, e.cyc, obs & e.msk, e.val & e.msk);
                end
                q.delete(k);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        // Reset, then idle with din at the reset level
        repeat (3) begin
            step();
            push_zero(cyc, "rst_hold");
        end
        rstn = 1'b1;
        repeat (20) begin
            step();
            push_zero(cyc, "idle");
        end

        // Clean edge on channel 0
        step();
        n = cyc;
        din[0] = 1'b1;
        for (int c = n + 1; c <= n + 4; c++) begin
            push(c, 0, 8'h01, 8'h00, "ce_dout_wait");
            push(c, 1, 8'h01, 8'h00, "ce_rise_wait");
            push(c, 3, 8'h01, 8'h00, "ce_sticky_wait");
        end
        push(n + 5, 0, 8'h01, 8'h01, "ce_dout");
        push(n + 5, 1, 8'h01, 8'h01, "ce_rise");
        push(n + 5, 2, 8'h01, 8'h00, "ce_fall");
        push(n + 5, 3, 8'h01, 8'h01, "ce_sticky");
        push(n + 5, 4, 8'h01, 8'h01, "ce_irq");
        push(n + 6, 0, 8'h01, 8'h01, "ce_dout_hold");
        push(n + 6, 1, 8'h01, 8'h00, "ce_rise_end");
        repeat (7) step();
        irq_mask = 8'h00;
        push(cyc, 4, 8'h01, 8'h00, "ce_irq_masked");
        push(cyc, 3, 8'h01, 8'h01, "ce_sticky_hold");
        chg_clr[0] = 1'b1;
        step();
        chg_clr[0] = 1'b0;
        push(cyc, 3, 8'h01, 8'h00, "ce_sticky_clr");
        step();
        irq_mask = 8'h01;
        push(cyc, 4, 8'h01, 8'h00, "ce_irq_after_clr");

        // Glitch rejection: channel 3 high for 2 clocks
        step();
        n = cyc;
        din[3] = 1'b1;
        for (int c = n + 1; c <= n + 10; c++) begin
            push(c, 0, 8'h08, 8'h00, "gr_dout");
            push(c, 1, 8'h08, 8'h00, "gr_rise");
            push(c, 2, 8'h08, 8'h00, "gr_fall");
            push(c, 3, 8'h08, 8'h00, "gr_sticky");
        end
        repeat (2) step();
        din[3] = 1'b0;
        while (cyc < n + 10) step();

        // Glitch boundary: channel 3 high for 3 clocks
        step();
        n = cyc;
        din[3] = 1'b1;
        for (int c = n + 1; c <= n + 12; c++) begin
            push(c, 0, 8'h08, (c >= n + 5 && c <= n + 7) ? 8'h08 : 8'h00, "gb_dout");
            push(c, 1, 8'h08, (c == n + 5) ? 8'h08 : 8'h00, "gb_rise");
            push(c, 2, 8'h08, (c == n + 8) ? 8'h08 : 8'h00, "gb_fall");
            push(c, 3, 8'h08, (c >= n + 5) ? 8'h08 : 8'h00, "gb_sticky");
        end
        repeat (3) step();
        din[3] = 1'b0;
        while (cyc < n + 12) step();

        // Interrupted run: channel 5 high 2, low 1, then high (held)
        step();
        n = cyc;
        din[5] = 1'b1;
        for (int c = n + 1; c <= n + 10; c++) begin
            push(c, 0, 8'h20, (c >= n + 8) ? 8'h20 : 8'h00, "ir_dout");
            push(c, 1, 8'h20, (c == n + 8) ? 8'h20 : 8'h00, "ir_rise");
        end
        repeat (2) step();
        din[5] = 1'b0;
        step();
        din[5] = 1'b1;
        while (cyc < n + 10) step();

        // Bypass on channel 2, toggling every clock, with a clear racing a change
        step();
        n = cyc;
        bypass[2] = 1'b1;
        for (int c = n + 1; c <= n + 12; c++) begin
            push(c, 0, 8'h04, (c >= n + 3 && c <= n + 10 && ((c - n - 3) % 2 == 0)) ? 8'h04 : 8'h00, "byp_dout");
            push(c, 1, 8'h04, (c >= n + 3 && c <= n + 10 && ((c - n - 3) % 2 == 0)) ? 8'h04 : 8'h00, "byp_rise");
            push(c, 2, 8'h04, (c >= n + 4 && c <= n + 10 && ((c - n - 3) % 2 == 1)) ? 8'h04 : 8'h00, "byp_fall");
        end
        for (int c = n + 3; c <= n + 11; c++) begin
            push(c, 3, 8'h04, 8'h04, "byp_sticky_race");
        end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            din[2]     = (k % 2 == 0);
            chg_clr[2] = (k == 4);
        end
        while (cyc < n + 11) step();
        bypass[2]  = 1'b0;
        chg_clr[2] = 1'b1;
        step();
        chg_clr[2] = 1'b0;
        push(cyc, 3, 8'h04, 8'h00, "byp_sticky_clr");

        // Asynchronous reset pulse mid-run
        step();
        irq_mask = 8'hFF;
        push(cyc, 4, 8'h01, 8'h01, "pre_rst_irq");
        push(cyc, 0, 8'hFF, 8'h21, "pre_rst_dout");
        push(cyc, 3, 8'hFF, 8'h28, "pre_rst_sticky");
        step();
        #1;
        rstn = 1'b0;
        push_zero(cyc, "async_rst");
        step();
        push_zero(cyc, "rst_held");
        rstn = 1'b1;
        n = cyc;
        for (int c = n + 1; c <= n + 4; c++) begin
            push(c, 0, 8'h21, 8'h00, "post_rst_wait");
        end
        push(n + 5, 0, 8'h21, 8'h21, "post_rst_dout");
        push(n + 5, 1, 8'h21, 8'h21, "post_rst_rise");
        push(n + 5, 4, 8'h01, 8'h01, "post_rst_irq");

        // Drain outstanding expectations within a bounded number of cycles
        for (int t = 0; t < 50 && q.size() > 0; t++) step();
        checks++;
        assert (q.size() == 0)
        else begin
            errors++;
            $error("FAIL drain: observed %0d pending expectations, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
